// File: rtl/lm07_sio_responder.sv
// LM07 sensor-side responder for the 3-wire SIO link: serves a temperature/ID word, then captures a shutdown command.
// Latency: SYNC_STAGES+1 SYSCLK cycles from any CS/SCK pin edge to the matching output change.
// Backpressure: none; the host owns SCK, and temp_valid samples arriving mid-transfer are held until CS rises.
module lm07_sio_responder #(
    parameter int          TEMP_BITS   = 13,
    parameter logic [15:0] ID_WORD     = 16'h800F,
    parameter logic [7:0]  SHDN_CMD    = 8'hFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 SYSCLK,
    input  logic                 RSTN,
    input  logic                 CS,
    input  logic                 SCK,
    input  logic                 SIO_IN,
    output logic                 SIO_OUT,
    output logic                 SIO_OE,
    input  logic [TEMP_BITS-1:0] temp_in,
    input  logic                 temp_valid,
    output logic                 shutdown,
    output logic                 xfer_done
);

    localparam int PAD_BITS = 16 - TEMP_BITS;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    logic [SYNC_STAGES-1:0] cs_s, sck_s, sio_s;
    logic                   cs_prev, sck_prev;
    logic                   cs_q, sck_q, sio_q;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    state_t                 state_q, state_d;
    logic [15:0]            shift_out;
    logic [15:0]            tx_word;
    logic [5:0]             edge_cnt;
    logic [7:0]             cmd_reg;
    logic                   cmd_valid;
    logic [TEMP_BITS-1:0]   temp_reg, pend_temp;
    logic                   pend_vld;

    logic load_word, do_shift, end_read, cnt_inc, cap_bit, set_valid, finish;

    // CS idles high out of reset so a low pin at release still reads as a fresh falling edge
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cs_s     <= '1;
            sck_s    <= '0;
            sio_s    <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            cs_s[0]  <= CS;
            sck_s[0] <= SCK;
            sio_s[0] <= SIO_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_s[i]  <= cs_s[i-1];
                sck_s[i] <= sck_s[i-1];
                sio_s[i] <= sio_s[i-1];
            end
            cs_prev  <= cs_q;
            sck_prev <= sck_q;
        end
    end

    assign cs_q     = cs_s[SYNC_STAGES-1];
    assign sck_q    = sck_s[SYNC_STAGES-1];
    assign sio_q    = sio_s[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_q;
    assign cs_rise  = ~cs_prev & cs_q;
    assign sck_rise = ~sck_prev & sck_q;
    assign sck_fall = sck_prev & ~sck_q;

    assign tx_word  = shutdown ? ID_WORD : {temp_reg, {PAD_BITS{1'b1}}};
    assign SIO_OUT  = shift_out[15];

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        do_shift  = 1'b0;
        end_read  = 1'b0;
        cnt_inc   = 1'b0;
        cap_bit   = 1'b0;
        set_valid = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    load_word = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                if (cs_rise) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    cnt_inc = 1'b1;
                end else if (sck_fall) begin
                    if (edge_cnt < 6'd16) begin
                        do_shift = 1'b1;
                    end else begin
                        end_read = 1'b1;
                        state_d  = WRITE;
                    end
                end
            end
            WRITE: begin
                if (cs_rise) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    cnt_inc = 1'b1;
                    cap_bit = 1'b1;
                    if (edge_cnt == 6'd31) begin
                        set_valid = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            shift_out <= '0;
            SIO_OE    <= 1'b0;
            edge_cnt  <= '0;
            cmd_reg   <= '0;
            cmd_valid <= 1'b0;
            shutdown  <= 1'b0;
            xfer_done <= 1'b0;
            temp_reg  <= '0;
            pend_temp <= '0;
            pend_vld  <= 1'b0;
        end else begin
            xfer_done <= finish;
            if (load_word) begin
                shift_out <= tx_word;
                SIO_OE    <= 1'b1;
                edge_cnt  <= '0;
                cmd_reg   <= '0;
            end
            if (cnt_inc)   edge_cnt  <= edge_cnt + 6'd1;
            if (do_shift)  shift_out <= {shift_out[14:0], 1'b0};
            if (end_read)  SIO_OE    <= 1'b0;
            // only the last eight captured bits survive: the high command byte is don't-care
            if (cap_bit)   cmd_reg   <= {cmd_reg[6:0], sio_q};
            if (set_valid) cmd_valid <= 1'b1;
            if (finish) begin
                SIO_OE    <= 1'b0;
                cmd_valid <= 1'b0;
                if (cmd_valid) shutdown <= (cmd_reg == SHDN_CMD);
                if (pend_vld)  temp_reg <= pend_temp;
                pend_vld  <= 1'b0;
            end
            // a strobe coinciding with CS rise lands after the pending sample, so the newest wins
            if (temp_valid && !shutdown) begin
                if (state_q == IDLE || finish) begin
                    temp_reg <= temp_in;
                end else begin
                    pend_temp <= temp_in;
                    pend_vld  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lm07_sio_responder.sv
// Bench for lm07_sio_responder: a host model drives CS/SCK/SIO_IN and a transaction-level sensor model
// predicts read words, shutdown, SIO_OE and xfer_done (outputs trail pin events by SYNC_STAGES+1 cycles).
module tb_lm07_sio_responder;

    localparam int H = 6;

    logic        SYSCLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        CS = 1'b1;
    logic        SCK = 1'b0;
    logic        SIO_IN = 1'b0;
    logic        SIO_OUT, SIO_OE, shutdown, xfer_done;
    logic [12:0] temp_in = '0;
    logic        temp_valid = 1'b0;

    lm07_sio_responder dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .CS         (CS),
        .SCK        (SCK),
        .SIO_IN     (SIO_IN),
        .SIO_OUT    (SIO_OUT),
        .SIO_OE     (SIO_OE),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .shutdown   (shutdown),
        .xfer_done  (xfer_done)
    );

    always #5 SYSCLK = ~SYSCLK;

    int errors = 0;
    int checks = 0;

    // sensor model state
    logic [12:0] m_temp = '0;
    logic [12:0] m_pend = '0;
    logic        m_pend_vld = 1'b0;
    logic        m_shdn = 1'b0;
    // output levels implied by the pins right now; the DUT follows them two compare slots later
    logic        m_oe_pin = 1'b0;
    logic        m_done_pin = 1'b0;
    logic        chk_en = 1'b0;
    logic [2:0]  h_oe = '0;
    logic [2:0]  h_done = '0;
    logic [2:0]  h_sd = '0;

    int          nt [6] = '{0, 8, 16, 20, 32, 32};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge SYSCLK);
            #2;
            h_oe   = {h_oe[1:0], m_oe_pin};
            h_done = {h_done[1:0], m_done_pin};
            h_sd   = {h_sd[1:0], m_shdn};
            if (chk_en) begin
                check("sio_oe", {31'd0, SIO_OE}, {31'd0, h_oe[2]});
                check("xfer_done", {31'd0, xfer_done}, {31'd0, h_done[2]});
                check("shutdown", {31'd0, shutdown}, {31'd0, h_sd[2]});
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic strobe_idle(input logic [12:0] v);
        @(negedge SYSCLK);
        temp_in = v;
        temp_valid = 1'b1;
        if (!m_shdn) m_temp = v;
        @(negedge SYSCLK);
        temp_valid = 1'b0;
        repeat (4) @(negedge SYSCLK);
    endtask

    task automatic xfer(input int nsck, input logic [15:0] wdata, input int st_at, input logic [12:0] sv,
                        output logic [15:0] rdata, output logic [15:0] exp_word, output logic stable);
        logic [15:0] got;
        logic ok;
        got = '0;
        ok = 1'b1;
        @(negedge SYSCLK);
        CS = 1'b0;
        m_oe_pin = 1'b1;
        exp_word = m_shdn ? 16'h800F : {m_temp, 3'b111};
        repeat (H) @(negedge SYSCLK);
        for (int i = 1; i <= nsck; i++) begin
            SCK = 1'b1;
            if (i <= 16) got[16-i] = SIO_OUT;
            if (i == st_at) begin
                temp_in = sv;
                temp_valid = 1'b1;
                if (!m_shdn) begin
                    m_pend = sv;
                    m_pend_vld = 1'b1;
                end
            end
            @(negedge SYSCLK);
            temp_valid = 1'b0;
            repeat (H-2) @(negedge SYSCLK);
            if (i <= 16 && SIO_OUT !== got[16-i]) ok = 1'b0;
            @(negedge SYSCLK);
            SCK = 1'b0;
            if (i == 16) m_oe_pin = 1'b0;
            if (i >= 16 && i < 32) SIO_IN = wdata[31-i];
            repeat (H) @(negedge SYSCLK);
        end
        CS = 1'b1;
        m_oe_pin = 1'b0;
        m_done_pin = 1'b1;
        if (nsck >= 32) m_shdn = (wdata[7:0] == 8'hFF);
        if (m_pend_vld) begin
            m_temp = m_pend;
            m_pend_vld = 1'b0;
        end
        @(negedge SYSCLK);
        m_done_pin = 1'b0;
        SIO_IN = 1'b0;
        repeat (8) @(negedge SYSCLK);
        rdata = got;
        stable = ok;
    endtask

    task automatic read_lit(input string name, input int nsck, input logic [15:0] wdata,
                            input int st_at, input logic [12:0] sv, input logic [15:0] lit);
        logic [15:0] r, e;
        logic s;
        xfer(nsck, wdata, st_at, sv, r, e, s);
        check(name, {16'd0, r}, {16'd0, lit});
        check({name, "_stable"}, {31'd0, s}, 32'd1);
    endtask

    initial begin
        logic [15:0] r, e, mask, ones;
        logic        s;
        logic [15:0] wd;
        int          nsck, st;

        ones = 16'hFFFF;
        #2;
        check("rst_sio_out", {31'd0, SIO_OUT}, 32'd0);
        check("rst_sio_oe", {31'd0, SIO_OE}, 32'd0);
        check("rst_shutdown", {31'd0, shutdown}, 32'd0);
        check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
        repeat (3) @(negedge SYSCLK);
        RSTN = 1'b1;
        repeat (4) @(negedge SYSCLK);
        chk_en = 1'b1;

        strobe_idle(13'h0190);
        read_lit("t1_word", 16, 16'h0000, -1, 13'h0, 16'h0C87);

        strobe_idle(13'h1E70);
        read_lit("t2_word", 16, 16'h0000, -1, 13'h0, 16'hF387);

        read_lit("t3_word", 32, 16'h00FF, -1, 13'h0, 16'hF387);
        check("t3_shdn_set", {31'd0, shutdown}, 32'd1);
        read_lit("t3_id", 16, 16'h0000, -1, 13'h0, 16'h800F);
        strobe_idle(13'h0010);

        read_lit("t4_id", 32, 16'h0000, -1, 13'h0, 16'h800F);
        check("t4_shdn_clr", {31'd0, shutdown}, 32'd0);
        read_lit("t4_word", 16, 16'h0000, -1, 13'h0, 16'hF387);

        read_lit("t5_word", 24, 16'hFFFF, -1, 13'h0, 16'hF387);
        check("t5_shdn_kept", {31'd0, shutdown}, 32'd0);
        check("t5_oe_off", {31'd0, SIO_OE}, 32'd0);
        read_lit("t5_next", 16, 16'h0000, -1, 13'h0, 16'hF387);

        read_lit("t6_old", 16, 16'h0000, 8, 13'h0320, 16'hF387);
        read_lit("t6_new", 16, 16'h0000, -1, 13'h0, 16'h1907);

        read_lit("t7_pre", 32, 16'h12FF, -1, 13'h0, 16'h1907);
        check("t7_shdn_set", {31'd0, shutdown}, 32'd1);
        chk_en = 1'b0;
        @(negedge SYSCLK);
        CS = 1'b0;
        repeat (H) @(negedge SYSCLK);
        SCK = 1'b1;
        repeat (H) @(negedge SYSCLK);
        SCK = 1'b0;
        repeat (2) @(negedge SYSCLK);
        check("t7_oe_before", {31'd0, SIO_OE}, 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        check("t7_oe_async", {31'd0, SIO_OE}, 32'd0);
        check("t7_shdn_async", {31'd0, shutdown}, 32'd0);
        @(negedge SYSCLK);
        CS = 1'b1;
        repeat (3) @(negedge SYSCLK);
        RSTN = 1'b1;
        m_temp = '0;
        m_pend_vld = 1'b0;
        m_shdn = 1'b0;
        m_oe_pin = 1'b0;
        m_done_pin = 1'b0;
        repeat (6) @(negedge SYSCLK);
        chk_en = 1'b1;
        read_lit("t7_word", 16, 16'h0000, -1, 13'h0, 16'h0007);

        for (int k = 0; k < 30; k++) begin
            nsck = nt[$urandom_range(0, 5)];
            wd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) wd[7:0] = 8'hFF;
            if ($urandom_range(0, 2) == 0) strobe_idle(13'($urandom_range(0, 8191)));
            st = -1;
            if (nsck > 0 && $urandom_range(0, 1) == 1) st = int'($urandom_range(1, nsck));
            xfer(nsck, wd, st, 13'($urandom_range(0, 8191)), r, e, s);
            if (nsck > 0) begin
                mask = ~(ones >> nsck);
                check("rand_word", {16'd0, r & mask}, {16'd0, e & mask});
                check("rand_stable", {31'd0, s}, 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lm07_sio_responder.md
Name: lm07_sio_responder

Overview:
- Synthesizable, SYSCLK-domain model of the LM07 temperature-sensor end of the 3-wire SPI/MICROWIRE link (CS, SCK, SIO).
- Answers the existing LM07 read controller: shifts out a 16-bit temperature word, then captures an optional 16-bit command word that controls shutdown.
- Temperature is loaded from a parallel source, such as an ADC stub or a testbench register.
- Used for on-FPGA loopback of the reader and as a drop-in replacement for the behavioural sensor model.

Parameters:
- TEMP_BITS, 13, width of two's-complement temperature; LSB = 0.0625 degC.
- ID_WORD, 16'h800F, word returned on reads while in shutdown.
- SHDN_CMD, 8'hFF, command low byte that selects shutdown.
- SYNC_STAGES, 2, synchronizer depth on CS, SCK, SIO_IN.

Ports:
- SYSCLK, input, 1, system clock; must be at least 8x SCK frequency.
- RSTN, input, 1, asynchronous active-low reset.
- CS, input, 1, chip select from host; active low.
- SCK, input, 1, serial clock from host; idles low.
- SIO_IN, input, 1, SIO pad input (host write data).
- SIO_OUT, output, 1, SIO pad output data.
- SIO_OE, output, 1, SIO pad output enable; 1 = responder drives.
- temp_in, input, TEMP_BITS, new temperature sample.
- temp_valid, input, 1, one-cycle strobe qualifying temp_in.
- shutdown, output, 1, current shutdown state.
- xfer_done, output, 1, one-cycle pulse when CS rises after a transaction.

Behaviour:
- Reset (RSTN low, async):
  - SIO_OUT=0, SIO_OE=0, shutdown=0, xfer_done=0.
  - Temperature register = 0; pending flag cleared; edge counter = 0; command register = 0.
- Synchronization:
  - CS, SCK and SIO_IN pass through SYNC_STAGES flops.
  - Edges are detected on the last two synchronized samples.
  - All latencies below are measured from the pin edge and equal SYNC_STAGES+1 SYSCLK cycles.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - SIO_OE=0.
  - On synchronized CS falling edge: load shift_out = shutdown ? ID_WORD : {temp_reg, 3'b111}.
  - Same cycle: SIO_OE=1, SIO_OUT = shift_out[15], edge_cnt=0; go to READ.
- READ:
  - Each synchronized SCK rising edge increments edge_cnt.
  - Each SCK falling edge while edge_cnt<16 shifts shift_out left and presents the new MSB on SIO_OUT.
  - Data therefore changes on SCK fall and is stable for the host's rising-edge sample.
  - On the SCK falling edge following rising edge 16: SIO_OE=0, go to WRITE.
- WRITE:
  - SCK rising edges 17..32 sample synchronized SIO_IN into cmd_reg MSB-first.
  - After rising edge 32: set cmd_valid, go to DONE.
- DONE: further SCK edges are ignored; SIO_OE stays 0.
- CS rise, from any non-IDLE state:
  - SIO_OE=0 within SYNC_STAGES+1 cycles.
  - xfer_done pulses for 1 cycle; go to IDLE.
  - If cmd_valid: shutdown <= (cmd_reg[7:0]==SHDN_CMD); the high byte is don't-care.
  - If cmd_valid is 0 (aborted or read-only transfer), shutdown is unchanged and the partial command is discarded.
  - cmd_valid is cleared.
- Temperature update:
  - temp_valid while in IDLE and not in shutdown loads temp_reg immediately.
  - temp_valid during a transaction stores the sample in a pending register; it is applied on CS rise, in the same cycle as xfer_done.
  - The latest pending sample wins.
  - In shutdown, temp_valid is ignored and temp_reg is frozen.
- Simultaneous events:
  - CS rise plus temp_valid in the same cycle: the new sample is applied after the pending one, so the newest value is kept.
  - CS fall in the same cycle as a temp_valid load in IDLE: the word shifted out uses the old temp_reg.
- CS rise followed by CS fall within 1 synchronized cycle is treated as two transactions; no merging.
- SCK edges while CS is high are ignored.

Test Plan:
1. Reset, temp_in=13'h0190 (+25 degC) strobed, 16-clock read → host captures 16'h0C87; SIO_OE high only between CS fall and the 16th SCK fall; xfer_done pulses once.
2. temp_in=13'h1E70 (-25 degC), read → 16'hF387; SIO_OUT stable across every SCK rising edge.
3. Read 16 bits then write 16'h00FF, CS high → shutdown=1; next read returns 16'h800F; temp_valid with 13'h0010 in shutdown leaves the following post-exit read at the old value.
4. In shutdown, full transfer writing 16'h0000 → shutdown=0; next read returns {temp_reg, 3'b111}.
5. CS released after 24 SCK cycles with partial 16'hFF.. → shutdown unchanged, SIO_OE=0; next transfer starts cleanly at MSB.
6. temp_valid 13'h0320 pulsed mid-read → current word still holds the old value; the next read returns 16'h1907.
7. RSTN asserted mid-READ → SIO_OE=0 immediately (async); after release, a read returns 16'h0007.
